// File: rtl/send_arbiter_pkg.sv
// Shared types and defaults for the two-requester send arbiter.
package send_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int DATA_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/send_arbiter_rr_pick2.sv
// Two-way round-robin pick with a registered last-served pointer.
module rr_pick2 (
    input  logic       clkCPU,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       served2,
    output logic [1:0] win
);

    // 1 = requester 2 was served last, so requester 1 wins the next tie
    logic last2;

    always_comb begin
        win = req;
        if (req == 2'b11)
            win = last2 ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clkCPU) begin
        if (rst)
            last2 <= 1'b1;
        else if (upd)
            last2 <= served2;
    end

endmodule

// File: rtl/send_arbiter.sv
// Arbitrates two send requesters onto one shared link with ack/timeout handling.
module send_arbiter
    import send_arbiter_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clkCPU,
    input  logic              rst,
    input  logic              insend1,
    input  logic              insend2,
    input  logic [DATA_W-1:0] indata1,
    input  logic [DATA_W-1:0] indata2,
    output logic              outack1,
    output logic              outack2,
    output logic              busSend,
    output logic [DATA_W-1:0] busData,
    input  logic              busAck,
    output logic [1:0]        busGrant,
    output logic              timeoutErr
);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] win;
    logic       expire;
    logic       leave_busy;

    assign expire     = (cnt == 4'(TIMEOUT_CYC - 1));
    assign leave_busy = (state == BUSY) && (busAck || expire);

    rr_pick2 u_pick (
        .clkCPU  (clkCPU),
        .rst     (rst),
        .req     ({insend2, insend1}),
        .upd     (leave_busy),
        .served2 (busGrant[1]),
        .win     (win)
    );

    always_ff @(posedge clkCPU) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            busSend    <= 1'b0;
            busData    <= '0;
            busGrant   <= 2'b00;
            outack1    <= 1'b0;
            outack2    <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win != 2'b00) begin
                        busData  <= win[0] ? indata1 : indata2;
                        busSend  <= 1'b1;
                        busGrant <= win;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // ack takes priority over a timeout landing on the same edge
                    if (busAck || expire) begin
                        busSend    <= 1'b0;
                        outack1    <= busGrant[0];
                        outack2    <= busGrant[1];
                        timeoutErr <= !busAck;
                        state      <= RELEASE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RELEASE: begin
                    outack1    <= 1'b0;
                    outack2    <= 1'b0;
                    timeoutErr <= 1'b0;
                    busGrant   <= 2'b00;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_send_arbiter.sv
// Directed self-checking bench for send_arbiter.
module tb_send_arbiter;

    logic        clkCPU = 1'b0;
    logic        rst;
    logic        insend1, insend2;
    logic [15:0] indata1, indata2;
    logic        outack1, outack2;
    logic        busSend;
    logic [15:0] busData;
    logic        busAck;
    logic [1:0]  busGrant;
    logic        timeoutErr;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    send_arbiter #(.DATA_W(16), .TIMEOUT_CYC(16)) dut (
        .clkCPU     (clkCPU),
        .rst        (rst),
        .insend1    (insend1),
        .insend2    (insend2),
        .indata1    (indata1),
        .indata2    (indata2),
        .outack1    (outack1),
        .outack2    (outack2),
        .busSend    (busSend),
        .busData    (busData),
        .busAck     (busAck),
        .busGrant   (busGrant),
        .timeoutErr (timeoutErr)
    );

    always #5 clkCPU = ~clkCPU;

    task automatic step();
        @(posedge clkCPU);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {busSend, busGrant, outack2, outack1, timeoutErr}
    function automatic logic [5:0] ctl();
        return {busSend, busGrant, outack2, outack1, timeoutErr};
    endfunction

    initial begin
        int n;
        rst = 1'b1; insend1 = 0; insend2 = 0; indata1 = '0; indata2 = '0; busAck = 0;
        step(); step();
        chk("reset_ctl", 32'(ctl()), 32'h0);
        chk("reset_data", 32'(busData), 32'h0);
        rst = 1'b0;

        // busAck in IDLE is ignored
        busAck = 1; step();
        chk("idle_ack_ignored", 32'(ctl()), 32'h0);
        busAck = 0;

        // single request, ack after 3 BUSY cycles
        insend1 = 1; indata1 = 16'hA5A5; step();
        chk("single_grant", 32'(ctl()), 32'b1_01_00_0);
        chk("single_data", 32'(busData), 32'hA5A5);
        step(); step();
        busAck = 1; step();
        chk("single_ack", 32'(ctl()), 32'b0_01_01_0);
        insend1 = 0; busAck = 0; step();
        chk("single_release", 32'(ctl()), 32'h0);
        chk("single_hold_data", 32'(busData), 32'hA5A5);

        // tie after reset: req1 first, then req2
        rst = 1; step(); rst = 0;
        insend1 = 1; insend2 = 1; indata1 = 16'h1111; indata2 = 16'h2222; step();
        chk("tie1_grant", 32'(ctl()), 32'b1_01_00_0);
        chk("tie1_data", 32'(busData), 32'h1111);
        busAck = 1; step();
        chk("tie1_ack", 32'(ctl()), 32'b0_01_01_0);
        busAck = 0; insend1 = 0; step();
        chk("tie_release_no_grant", 32'(ctl()), 32'h0);
        step();
        chk("tie2_grant", 32'(ctl()), 32'b1_10_00_0);
        chk("tie2_data", 32'(busData), 32'h2222);
        busAck = 1; step();
        chk("tie2_ack", 32'(ctl()), 32'b0_10_10_0);
        insend2 = 0; busAck = 0; step();

        // timeout on requester 2: busSend high exactly 16 cycles
        insend2 = 1; indata2 = 16'hBEEF; step();
        n = 0;
        while (busSend && n < 40) begin
            n++;
            step();
        end
        chk("timeout_len", 32'(n), 32'd16);
        chk("timeout_pulse", 32'(ctl()), 32'b0_10_10_1);
        insend2 = 0; step();
        chk("timeout_release", 32'(ctl()), 32'h0);

        // ack on the final BUSY cycle beats the timeout
        insend1 = 1; indata1 = 16'h0F0F; step();
        for (int i = 0; i < 15; i++) step();
        chk("late_still_busy", 32'(ctl()), 32'b1_01_00_0);
        busAck = 1; step();
        chk("late_ack_wins", 32'(ctl()), 32'b0_01_01_0);
        insend1 = 0; busAck = 0; step();

        // reset in BUSY cycle 5 drops the transfer, then tie goes to req1
        insend1 = 1; indata1 = 16'h1234; step();
        for (int i = 0; i < 4; i++) step();
        rst = 1; step();
        chk("midrst_ctl", 32'(ctl()), 32'h0);
        chk("midrst_data", 32'(busData), 32'h0);
        rst = 0; insend1 = 0; step();
        chk("midrst_no_ack", 32'(ctl()), 32'h0);
        insend1 = 1; insend2 = 1; indata1 = 16'h1111; indata2 = 16'h2222; step();
        chk("midrst_tie_grant", 32'(ctl()), 32'b1_01_00_0);
        busAck = 1; step();
        insend1 = 0; insend2 = 0; busAck = 0; step();
        step();

        // payload latched at grant stays put
        insend1 = 1; indata1 = 16'h0001; step();
        indata1 = 16'hFFFF; step(); step();
        chk("stable_data", 32'(busData), 32'h0001);
        busAck = 1; step();
        insend1 = 0; busAck = 0; step();
        chk("stable_after_release", 32'(busData), 32'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/send_arbiter.md
SEND_ARBITER -- requirements
Module: send_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of every data port.
REQ-002 Parameter TIMEOUT_CYC, default 16, SHALL set the maximum number of BUSY cycles waited for busAck.
REQ-003 clkCPU  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 insend1 / insend2  input  1 each  SHALL be the requester 1/2 send requests, held high until the matching outack.
REQ-006 indata1 / indata2  input  DATA_W each  SHALL be the requester 1/2 payloads, valid while insendN is high.
REQ-007 outack1 / outack2  output  1 each  SHALL be one-cycle completion pulses to requester 1/2.
REQ-008 busSend  output  1  SHALL be the shared-link send strobe.
REQ-009 busData  output  DATA_W  SHALL be the shared-link payload.
REQ-010 busAck  input  1  SHALL be the shared-link acknowledge.
REQ-011 busGrant  output  2  SHALL be one-hot owner of the link (01 = req1, 10 = req2, 00 = none).
REQ-012 timeoutErr  output  1  SHALL be a one-cycle pulse marking an aborted transfer.

Function
REQ-013 FSM SHALL have states IDLE, BUSY, RELEASE.
REQ-014 IDLE: if any insendN is sampled high, the winner's data SHALL be latched into busData; busSend=1, busGrant=winner, state->BUSY, all on that same edge.
REQ-015 Arbitration SHALL be round-robin: a single request wins outright; with both requests high, the requester not served last wins.
REQ-016 Last-served pointer SHALL update only on leaving BUSY, whether by ack or by timeout.
REQ-017 busData SHALL stay stable throughout BUSY; indataN changes after the grant SHALL be ignored.
REQ-018 BUSY: a 4-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle with busAck low.
REQ-019 BUSY with busAck high: busSend->0, outackN (granted) ->1, state->RELEASE on that edge.
REQ-020 BUSY with busAck low and counter == TIMEOUT_CYC-1: busSend->0, outackN->1, timeoutErr->1, state->RELEASE. busSend high therefore lasts at most TIMEOUT_CYC cycles.
REQ-021 busAck and timeout on the same edge: ack SHALL win, and timeoutErr SHALL stay 0.
REQ-022 RELEASE SHALL last exactly one cycle: outackN and timeoutErr drop, busGrant->00, state->IDLE; insendN SHALL be ignored during RELEASE.
REQ-023 busAck SHALL be ignored in IDLE and RELEASE.
REQ-024 Latency: request sampled at edge N -> busSend high after N. busAck sampled at edge M -> outack high after M. Earliest next grant is at edge M+2.
REQ-025 busData SHALL hold its last value when not BUSY.
REQ-026 A requester dropping insendN during BUSY SHALL NOT abort the transfer.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=IDLE, busSend=0, busData=0, busGrant=00, outack1=outack2=0, timeoutErr=0, counter=0, pointer=req2-last (so req1 wins the first tie).
REQ-028 rst SHALL override every other input, including mid-BUSY; an in-flight transfer is dropped with no outack and no timeoutErr.

Structure
REQ-029 Shared package SHALL hold the state enum (IDLE, BUSY, RELEASE), the DATA_W default and the TIMEOUT_CYC default.
REQ-030 Round-robin pick plus last-served pointer SHALL be one sub-module, rr_pick2; counter, FSM and datapath stay in send_arbiter.

Verification
REQ-031 Single request: insend1=1, indata1=16'hA5A5; busAck after 3 cycles -> busData=A5A5, busGrant=01, outack1 one-cycle pulse, timeoutErr=0.
REQ-032 Tie after reset: both insend high, indata1=0x1111, indata2=0x2222 -> first transfer 0x1111, second 0x2222; an outack pulse for each.
REQ-033 Timeout: insend2=1, busAck held 0 -> busSend high exactly 16 cycles, then outack2 and timeoutErr pulse together.
REQ-034 Ack on cycle 16: busAck rises on the final BUSY cycle -> outack pulses, timeoutErr=0.
REQ-035 Reset mid-BUSY: rst at BUSY cycle 5 -> next cycle all outputs 0, no outack; then a tie grants req1.
REQ-036 Data stability: change indata1 from 0x0001 to 0xFFFF during BUSY -> busData remains 0x0001.
